rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_pkg.sv | 35 +++
 rtl/rst_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset cause codes
// and a small helper used to size the shared cycle counter.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_POR_HOLD,
    ST_REL_BUS,
    ST_REL_PERIPH,
    ST_REL_CORE,
    ST_RUN,
    ST_CORE_HOLD,
    ST_DRAIN,
    ST_PERIPH_HOLD
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR        = 2'd0,
    CAUSE_DBG_CORE   = 2'd1,
    CAUSE_DBG_PERIPH = 2'd2,
    CAUSE_SW         = 2'd3
  } rst_cause_e;

  localparam logic [1:0] CAUSE_CODE_POR        = 2'd0;
  localparam logic [1:0] CAUSE_CODE_DBG_CORE   = 2'd1;
  localparam logic [1:0] CAUSE_CODE_DBG_PERIPH = 2'd2;
  localparam logic [1:0] CAUSE_CODE_SW         = 2'd3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds and releases bus, peripheral and core reset domains in order,
// and services debug/software reset requests with a bus drain before peripheral reset.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned RST_MIN_CYCLES = 16,
  parameter int unsigned RELEASE_GAP    = 4,
  parameter int unsigned IDLE_TIMEOUT   = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dbg_core_rst_req_i,
  input  logic       dbg_periph_rst_req_i,
  input  logic       sw_core_rst_req_i,
  input  logic       bus_idle_i,
  output logic       core_rst_o,
  output logic       periph_rst_o,
  output logic       bus_rst_o,
  output logic       busy_o,
  output logic [1:0] rst_cause_o,
  output logic       drain_to_o
);

  localparam int unsigned CNT_MAX = max3(RST_MIN_CYCLES, RELEASE_GAP, IDLE_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(RST_MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  rst_state_e       state_q, state_d;
  rst_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_to_q, drain_to_d;
  logic             core_rst_q, core_rst_d;
  logic             periph_rst_q, periph_rst_d;
  logic             bus_rst_q, bus_rst_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    drain_to_d = drain_to_q;
    cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    unique case (state_q)
      ST_POR_HOLD:   if (cnt_q >= MIN_LAST) state_d = ST_REL_BUS;
      ST_REL_BUS:    if (cnt_q >= GAP_LAST) state_d = ST_REL_PERIPH;
      ST_REL_PERIPH: if (cnt_q >= GAP_LAST) state_d = ST_REL_CORE;
      ST_REL_CORE:   state_d = ST_RUN;
      ST_RUN: begin
        if (dbg_periph_rst_req_i) begin
          state_d = ST_DRAIN;
          cause_d = CAUSE_DBG_PERIPH;
        end else if (dbg_core_rst_req_i) begin
          state_d = ST_CORE_HOLD;
          cause_d = CAUSE_DBG_CORE;
        end else if (sw_core_rst_req_i) begin
          state_d = ST_CORE_HOLD;
          cause_d = CAUSE_SW;
        end
      end
      ST_CORE_HOLD: begin
        // A peripheral request escalates straight to drain so the core never leaves reset
        if (dbg_periph_rst_req_i) begin
          state_d = ST_DRAIN;
          cause_d = CAUSE_DBG_PERIPH;
        end else if (cnt_q >= MIN_LAST && !dbg_core_rst_req_i) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus_idle_i) begin
          state_d = ST_PERIPH_HOLD;
        end else if (cnt_q >= IDLE_LAST) begin
          state_d    = ST_PERIPH_HOLD;
          drain_to_d = 1'b1;
        end
      end
      ST_PERIPH_HOLD: if (cnt_q >= MIN_LAST && !dbg_periph_rst_req_i) state_d = ST_REL_BUS;
      default:        state_d = ST_POR_HOLD;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they are registered alongside it
    core_rst_d   = 1'b1;
    periph_rst_d = 1'b1;
    bus_rst_d    = 1'b1;
    unique case (state_d)
      ST_REL_BUS:                bus_rst_d = 1'b0;
      ST_REL_PERIPH, ST_CORE_HOLD, ST_DRAIN: begin
        bus_rst_d    = 1'b0;
        periph_rst_d = 1'b0;
      end
      ST_REL_CORE, ST_RUN: begin
        bus_rst_d    = 1'b0;
        periph_rst_d = 1'b0;
        core_rst_d   = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_POR_HOLD;
      cause_q      <= CAUSE_POR;
      cnt_q        <= '0;
      drain_to_q   <= 1'b0;
      core_rst_q   <= 1'b1;
      periph_rst_q <= 1'b1;
      bus_rst_q    <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      cnt_q        <= cnt_d;
      drain_to_q   <= drain_to_d;
      core_rst_q   <= core_rst_d;
      periph_rst_q <= periph_rst_d;
      bus_rst_q    <= bus_rst_d;
      busy_q       <= busy_d;
    end
  end

  assign core_rst_o   = core_rst_q;
  assign periph_rst_o = periph_rst_q;
  assign bus_rst_o    = bus_rst_q;
  assign busy_o       = busy_q;
  assign rst_cause_o  = cause_q;
  assign drain_to_o   = drain_to_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-on release order, core/peripheral reset
// sequences, drain timeout and reset abort, with hand-computed expected outputs.
module tb_rst_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       dbg_core_rst_req_i = 1'b0;
  logic       dbg_periph_rst_req_i = 1'b0;
  logic       sw_core_rst_req_i = 1'b0;
  logic       bus_idle_i = 1'b1;
  logic       core_rst_o, periph_rst_o, bus_rst_o, busy_o, drain_to_o;
  logic [1:0] rst_cause_o;
  logic [3:0] outs;

  int compared = 0;
  int mismatched = 0;

  // Outputs grouped as {core, periph, bus, busy} to keep the expected vectors short
  assign outs = {core_rst_o, periph_rst_o, bus_rst_o, busy_o};

  always #5 clk_i = ~clk_i;

  rst_seq_ctrl dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .dbg_core_rst_req_i  (dbg_core_rst_req_i),
    .dbg_periph_rst_req_i(dbg_periph_rst_req_i),
    .sw_core_rst_req_i   (sw_core_rst_req_i),
    .bus_idle_i          (bus_idle_i),
    .core_rst_o          (core_rst_o),
    .periph_rst_o        (periph_rst_o),
    .bus_rst_o           (bus_rst_o),
    .busy_o              (busy_o),
    .rst_cause_o         (rst_cause_o),
    .drain_to_o          (drain_to_o)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(5);
    compared++;
    if (outs !== 4'b1111 || rst_cause_o !== 2'd0 || drain_to_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got outs=%b cause=%0d to=%b want outs=1111 cause=0 to=0",
               outs, rst_cause_o, drain_to_o);
    end
  endtask

  task automatic test_por_release();
    rst_i = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      compared++;
      if (outs !== 4'b1111) begin
        mismatched++;
        $display("[TB] FAIL por_hold cycle %0d: got %b want 1111", i, outs);
      end
    end
    tick(1);
    compared++;
    if (outs !== 4'b1101) begin
      mismatched++;
      $display("[TB] FAIL por_bus_release: got %b want 1101", outs);
    end
    tick(3);
    compared++;
    if (outs !== 4'b1101) begin
      mismatched++;
      $display("[TB] FAIL por_periph_early: got %b want 1101", outs);
    end
    tick(1);
    compared++;
    if (outs !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL por_periph_release: got %b want 1001", outs);
    end
    tick(3);
    compared++;
    if (outs !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL por_core_early: got %b want 1001", outs);
    end
    tick(1);
    compared++;
    if (outs !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL por_core_release: got %b want 0001", outs);
    end
    tick(1);
    compared++;
    if (outs !== 4'b0000 || rst_cause_o !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL por_run: got outs=%b cause=%0d want outs=0000 cause=0", outs, rst_cause_o);
    end
  endtask

  task automatic test_sw_reset();
    sw_core_rst_req_i = 1'b1;
    tick(1);
    sw_core_rst_req_i = 1'b0;
    compared++;
    if (outs !== 4'b1001 || rst_cause_o !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL sw_enter: got outs=%b cause=%0d want outs=1001 cause=3", outs, rst_cause_o);
    end
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      compared++;
      if (outs !== 4'b1001) begin
        mismatched++;
        $display("[TB] FAIL sw_hold cycle %0d: got %b want 1001", i, outs);
      end
    end
    tick(1);
    compared++;
    if (outs !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL sw_release: got %b want 0000", outs);
    end
  endtask

  task automatic test_dbg_core_hold();
    dbg_core_rst_req_i = 1'b1;
    sw_core_rst_req_i  = 1'b1;
    tick(1);
    sw_core_rst_req_i = 1'b0;
    compared++;
    if (outs !== 4'b1001 || rst_cause_o !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL dbg_core_enter: got outs=%b cause=%0d want outs=1001 cause=1", outs, rst_cause_o);
    end
    for (int i = 1; i <= 39; i++) begin
      tick(1);
      compared++;
      if (outs !== 4'b1001) begin
        mismatched++;
        $display("[TB] FAIL dbg_core_hold cycle %0d: got %b want 1001", i, outs);
      end
    end
    dbg_core_rst_req_i = 1'b0;
    tick(1);
    compared++;
    if (outs !== 4'b0000 || rst_cause_o !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL dbg_core_release: got outs=%b cause=%0d want outs=0000 cause=1", outs, rst_cause_o);
    end
  endtask

  task automatic test_periph_drain();
    dbg_periph_rst_req_i = 1'b1;
    dbg_core_rst_req_i   = 1'b1;
    sw_core_rst_req_i    = 1'b1;
    bus_idle_i           = 1'b0;
    tick(1);
    dbg_periph_rst_req_i = 1'b0;
    dbg_core_rst_req_i   = 1'b0;
    sw_core_rst_req_i    = 1'b0;
    compared++;
    if (outs !== 4'b1001 || rst_cause_o !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL drain_enter: got outs=%b cause=%0d want outs=1001 cause=2", outs, rst_cause_o);
    end
    tick(9);
    compared++;
    if (outs !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL drain_wait: got %b want 1001", outs);
    end
    bus_idle_i = 1'b1;
    tick(1);
    compared++;
    if (outs !== 4'b1111 || drain_to_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drain_idle_exit: got outs=%b to=%b want outs=1111 to=0", outs, drain_to_o);
    end
    tick(15);
    compared++;
    if (outs !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL periph_hold: got %b want 1111", outs);
    end
    tick(1);
    compared++;
    if (outs !== 4'b1101) begin
      mismatched++;
      $display("[TB] FAIL periph_rel_bus: got %b want 1101", outs);
    end
    tick(4);
    compared++;
    if (outs !== 4'b1001) begin
      mismatched++;
      $display("[TB] FAIL periph_rel_periph: got %b want 1001", outs);
    end
    tick(4);
    compared++;
    if (outs !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL periph_rel_core: got %b want 0001", outs);
    end
    tick(1);
    compared++;
    if (outs !== 4'b0000 || rst_cause_o !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL periph_run: got outs=%b cause=%0d want outs=0000 cause=2", outs, rst_cause_o);
    end
  endtask

  task automatic test_timeout();
    bus_idle_i           = 1'b0;
    dbg_periph_rst_req_i = 1'b1;
    tick(1);
    dbg_periph_rst_req_i = 1'b0;
    tick(255);
    compared++;
    if (outs !== 4'b1001 || drain_to_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_last_wait: got outs=%b to=%b want outs=1001 to=0", outs, drain_to_o);
    end
    tick(1);
    compared++;
    if (outs !== 4'b1111 || drain_to_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_exit: got outs=%b to=%b want outs=1111 to=1", outs, drain_to_o);
    end
    bus_idle_i = 1'b1;
    tick(25);
    compared++;
    if (outs !== 4'b0000 || drain_to_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_sticky: got outs=%b to=%b want outs=0000 to=1", outs, drain_to_o);
    end
  endtask

  task automatic test_escalation_abort();
    sw_core_rst_req_i = 1'b1;
    tick(1);
    sw_core_rst_req_i = 1'b0;
    tick(5);
    dbg_periph_rst_req_i = 1'b1;
    bus_idle_i           = 1'b0;
    tick(1);
    dbg_periph_rst_req_i = 1'b0;
    compared++;
    if (outs !== 4'b1001 || rst_cause_o !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL escalate: got outs=%b cause=%0d want outs=1001 cause=2", outs, rst_cause_o);
    end
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      compared++;
      if (outs !== 4'b1001) begin
        mismatched++;
        $display("[TB] FAIL escalate_drain cycle %0d: got %b want 1001", i, outs);
      end
    end
    rst_i = 1'b1;
    tick(1);
    compared++;
    if (outs !== 4'b1111 || rst_cause_o !== 2'd0 || drain_to_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_reset: got outs=%b cause=%0d to=%b want outs=1111 cause=0 to=0",
               outs, rst_cause_o, drain_to_o);
    end
    rst_i      = 1'b0;
    bus_idle_i = 1'b1;
    tick(16);
    compared++;
    if (outs !== 4'b1101) begin
      mismatched++;
      $display("[TB] FAIL abort_rerelease: got %b want 1101", outs);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_por_release();
    test_sw_reset();
    test_dbg_core_hold();
    test_periph_drain();
    test_timeout();
    test_escalation_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
